mdu_iter: RTL and testbench
===========================

// Module: mdu_iter
// PURPOSE
//  Iterative multiply/divide unit on the execute side of the register file.
//  Consumes the RF read data (rd0/rd1) and produces one write-back
//  (wa/wd/we-valid) for the RF write port.
//  Radix-2 shift-add multiplier and restoring divider; one bit per cycle.
//  RISC-V M-extension semantics. Single outstanding operation; valid/ready on both sides.
// PARAMETERS
//  ADDR_WIDTH  5   RF address width (destination tag)
//  DATA_WIDTH  32  operand/result width W; iteration count = W
// PORTS
//  clk        in   1           clock, all state updates on posedge
//  rst        in   1           synchronous reset, active-high
//  in_valid   in   1           request valid
//  in_ready   out  1           unit can accept (1 only in IDLE)
//  op         in   3           0 MUL,1 MULH,2 MULHU,3 DIV,4 DIVU,5 REM,6 REMU,7 rsvd
//  src0       in   W           operand A (from rd0)
//  src1       in   W           operand B (from rd1)
//  wa_in      in   ADDR_WIDTH  destination register
//  flush      in   1           abort current op (pipeline redirect)
//  out_valid  out  1           result valid (= RF we request)
//  out_ready  in   1           write-back accepted this cycle
//  out_wa     out  ADDR_WIDTH  destination register of result
//  out_wd     out  W           result
//  busy       out  1           1 in CALC or DONE
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; busy=0; out_wa=0; out_wd=0;
//   counter=0. rst overrides flush and all inputs, also mid-operation.
//  FSM: IDLE -> CALC on in_valid&in_ready (op, operands, wa_in latched).
//   Special cases go IDLE -> DONE directly: div/rem with src1==0; signed
//   DIV/REM with src0=100..0 and src1=all-ones; op==7 (result 0).
//   CALC: W cycles, counter 0..W-1; CALC -> DONE after counter==W-1.
//   DONE: out_valid=1, out_wa/out_wd stable; DONE -> IDLE on out_ready.
//  Latency: accept edge N; normal ops out_valid high from cycle N+W+1
//   (33 cycles for W=32); special cases out_valid high from cycle N+1.
//  Back-to-back: no accept in the cycle out_ready is taken; in_ready
//   returns to 1 the cycle after leaving DONE.
//  Signed ops: operate on magnitudes; MULH sign = sign(A)^sign(B), product
//   2W bits, two's-complement negate when negative. DIV quotient sign =
//   sign(A)^sign(B); REM sign = sign(A). MULHU/DIVU/REMU unsigned.
//  Result select: MUL low W bits; MULH/MULHU high W bits of 2W product.
//  Div by zero: DIV/DIVU -> all ones; REM/REMU -> src0.
//  Signed overflow: DIV -> 100..0; REM -> 0.
//  wa_in==0 computed normally; RF discards the write.
//  out_wd changes only on DONE entry; held while out_valid & !out_ready.
//  flush in CALC or DONE: IDLE next cycle, out_valid=0, result dropped.
//   flush in IDLE with in_valid: request not accepted.
//  in_valid while busy: ignored; no internal queue.
// TESTING
//  MUL 7*6, wa=5 -> out_valid exactly 33 cycles after accept; wa=5, wd=42.
//  MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7%2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
//  DIV 5/0 -> 0xFFFFFFFF, REM 5%0 -> 5, DIV 0x80000000/-1 -> 0x80000000:
//   each with out_valid 1 cycle after accept.
//  out_ready=0 for 10 cycles in DONE -> out_valid, wa, wd held; in_ready=0.
//  flush at CALC cycle 10 -> IDLE next cycle, no out_valid; new MUL 3*3 -> 9.
//  rst at CALC cycle 20 -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative RISC-V M-extension multiply/divide unit: radix-2 shift-add multiply,
// restoring divide, one bit per cycle, single outstanding op with valid/ready.
module mdu_iter #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] src0,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [ADDR_WIDTH-1:0] wa_in,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_wa,
  output logic [DATA_WIDTH-1:0] out_wd,
  output logic                  busy
);
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULH  = 3'd1;
  localparam logic [2:0] OP_MULHU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_REM   = 3'd5;
  localparam logic [2:0] OP_REMU  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic [1:0]            r_state;
  logic [CW-1:0]         r_cnt;
  logic [2:0]            r_op;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic [W-1:0]          r_b;
  logic [2*W-1:0]        r_acc;
  logic [ADDR_WIDTH-1:0] r_wa;
  logic [W-1:0]          r_wd;

  logic           w_accept, w_is_div, w_signed, w_a_neg, w_b_neg;
  logic           w_div0, w_ovf, w_special;
  logic [W-1:0]   w_a_mag, w_b_mag, w_special_wd;
  logic [W:0]     w_sum, w_trial, w_diff;
  logic [2*W-1:0] w_acc_nxt, w_prod_s;
  logic [W-1:0]   w_quo, w_rem, w_result;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_wa    = r_wa;
  assign out_wd    = r_wd;

  assign w_accept  = in_valid & in_ready & ~flush;
  assign w_is_div  = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  assign w_signed  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign w_a_neg   = w_signed & src0[W-1];
  assign w_b_neg   = w_signed & src1[W-1];
  assign w_a_mag   = w_a_neg ? -src0 : src0;
  assign w_b_mag   = w_b_neg ? -src1 : src1;
  assign w_div0    = w_is_div && (src1 == '0);
  assign w_ovf     = ((op == OP_DIV) || (op == OP_REM)) && (src0 == MIN_NEG) && (src1 == '1);
  assign w_special = (op == OP_RSVD) || w_div0 || w_ovf;

  always_comb begin
    w_special_wd = '0;
    if (w_div0)
      w_special_wd = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : src0;
    else if (w_ovf)
      w_special_wd = (op == OP_DIV) ? MIN_NEG : '0;
  end

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    w_sum   = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_b} : {(W+1){1'b0}});
    w_trial = r_acc[2*W-1:W-1];
    w_diff  = w_trial - {1'b0, r_b};
    if (r_op >= OP_DIV) begin
      if (!w_diff[W])
        w_acc_nxt = {w_diff[W-1:0], r_acc[W-2:0], 1'b1};
      else
        w_acc_nxt = {w_trial[W-1:0], r_acc[W-2:0], 1'b0};
    end else begin
      w_acc_nxt = {w_sum, r_acc[W-1:1]};
    end
  end

  always_comb begin
    w_prod_s = r_neg_q ? -w_acc_nxt : w_acc_nxt;
    w_quo    = r_neg_q ? -w_acc_nxt[W-1:0] : w_acc_nxt[W-1:0];
    w_rem    = r_neg_r ? -w_acc_nxt[2*W-1:W] : w_acc_nxt[2*W-1:W];
    case (r_op)
      OP_MUL:           w_result = w_prod_s[W-1:0];
      OP_MULH, OP_MULHU: w_result = w_prod_s[2*W-1:W];
      OP_DIV, OP_DIVU:  w_result = w_quo;
      OP_REM, OP_REMU:  w_result = w_rem;
      default:          w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_b     <= '0;
      r_acc   <= '0;
      r_wa    <= '0;
      r_wd    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wa    <= wa_in;
            r_op    <= op;
            r_cnt   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            if (w_special) begin
              r_wd    <= w_special_wd;
              r_state <= S_DONE;
            end else begin
              r_acc   <= w_is_div ? {{W{1'b0}}, w_a_mag} : {{W{1'b0}}, w_b_mag};
              r_b     <= w_is_div ? w_b_mag : w_a_mag;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_acc <= w_acc_nxt;
            if (r_cnt == CW'(W - 1)) begin
              r_wd    <= w_result;
              r_cnt   <= '0;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (flush || out_ready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed M-extension cases, handshake/flush/reset
// behaviour, and randomized operations against an arithmetic reference model.
module tb_mdu_iter;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] src0;
  logic [31:0] src1;
  logic [4:0]  wa_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_wa;
  logic [31:0] out_wd;
  logic        busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  mdu_iter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src0(src0), .src1(src1), .wa_in(wa_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_wa(out_wa), .out_wd(out_wd), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    logic [63:0]     p;
    p = '0;
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = ua * ub; return p[63:32]; end
      3'd3: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return (o == 3'd7) || (o >= 3'd3 && b == 32'h0) ||
           ((o == 3'd3 || o == 3'd5) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Latency is counted in clock edges after the accepting edge: W for iterative ops,
  // 0 for special cases (out_valid already visible right after the accepting edge).
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa, input int hold);
    logic [31:0] exp_wd;
    int          exp_lat;
    int          lat;
    exp_wd  = model(o, a, b);
    exp_lat = is_special(o, a, b) ? 0 : 32;
    chk({tag, ".in_ready_pre"}, in_ready, 1);
    op = o; src0 = a; src1 = b; wa_in = wa; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".wa"}, out_wa, wa);
    chk({tag, ".wd"}, out_wd, exp_wd);
    if (hold > 0) begin
      op = 3'd0; src0 = $urandom; src1 = $urandom; wa_in = ~wa; in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        tick();
        chk({tag, ".hold_valid"}, out_valid, 1);
        chk({tag, ".hold_wa"}, out_wa, wa);
        chk({tag, ".hold_wd"}, out_wd, exp_wd);
        chk({tag, ".hold_in_ready"}, in_ready, 0);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, ".post_valid"}, out_valid, 0);
    chk({tag, ".post_busy"}, busy, 0);
    chk({tag, ".post_in_ready"}, in_ready, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".in_ready"}, in_ready, 1);
    chk({tag, ".out_valid"}, out_valid, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".out_wa"}, out_wa, 0);
    chk({tag, ".out_wd"}, out_wd, 0);
  endtask

  initial begin
    logic [2:0]  r_o;
    logic [31:0] r_a, r_b;
    int          seen_valid;

    rst = 1'b1; in_valid = 1'b0; op = '0; src0 = '0; src1 = '0; wa_in = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk_reset_outputs("reset");

    run_op("mul_7x6",    3'd0, 32'd7,          32'd6,          5'd5,  0);
    run_op("mulh_min",   3'd1, 32'h8000_0000,  32'h8000_0000,  5'd1,  0);
    run_op("mulhu_max",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  0);
    run_op("mulh_mixed", 3'd1, 32'hFFFF_FFF9,  32'd123456789,  5'd3,  0);
    run_op("div_m7_2",   3'd3, 32'hFFFF_FFF9,  32'd2,          5'd4,  0);
    run_op("rem_m7_2",   3'd5, 32'hFFFF_FFF9,  32'd2,          5'd6,  0);
    run_op("divu_100_7", 3'd4, 32'd100,        32'd7,          5'd7,  0);
    run_op("remu_100_7", 3'd6, 32'd100,        32'd7,          5'd8,  0);
    run_op("div_5_0",    3'd3, 32'd5,          32'd0,          5'd9,  0);
    run_op("rem_5_0",    3'd5, 32'd5,          32'd0,          5'd10, 0);
    run_op("divu_5_0",   3'd4, 32'd5,          32'd0,          5'd11, 0);
    run_op("div_ovf",    3'd3, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 0);
    run_op("rem_ovf",    3'd5, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 0);
    run_op("rsvd",       3'd7, 32'd1234,       32'd5678,       5'd14, 0);
    run_op("wa0",        3'd0, 32'd11,         32'd13,         5'd0,  0);
    run_op("hold_mul",   3'd0, 32'hDEAD_BEEF,  32'h1234_5678,  5'd21, 10);
    run_op("hold_div0",  3'd3, 32'd77,         32'd0,          5'd22, 3);

    // flush during CALC
    op = 3'd0; src0 = 32'hCAFE_F00D; src1 = 32'h0BAD_BEEF; wa_in = 5'd17; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("flush_calc.busy_pre", busy, 1);
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_calc.out_valid", out_valid, 0);
    chk("flush_calc.busy", busy, 0);
    chk("flush_calc.in_ready", in_ready, 1);
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen_valid++;
    end
    chk("flush_calc.no_result", seen_valid, 0);
    run_op("after_flush_mul", 3'd0, 32'd3, 32'd3, 5'd18, 0);

    // flush while a request is offered in IDLE
    op = 3'd4; src0 = 32'd50; src1 = 32'd5; wa_in = 5'd19; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle.busy", busy, 0);
    chk("flush_idle.in_ready", in_ready, 1);

    // flush while DONE drops the result
    op = 3'd3; src0 = 32'd9; src1 = 32'd0; wa_in = 5'd20; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("flush_done.valid_pre", out_valid, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_done.out_valid", out_valid, 0);
    chk("flush_done.in_ready", in_ready, 1);

    // reset mid-operation overrides a concurrent request
    op = 3'd1; src0 = 32'h1357_9BDF; src1 = 32'h2468_ACE0; wa_in = 5'd23; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    rst = 1'b1; in_valid = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
    chk_reset_outputs("rst_calc");

    for (int i = 0; i < 40; i++) begin
      r_o = 3'($urandom_range(0, 7));
      r_a = $urandom;
      r_b = $urandom;
      case ($urandom_range(0, 9))
        0: r_b = 32'h0;
        1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
        2: r_b = 32'($urandom_range(1, 15));
        3: r_b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op($sformatf("rand%0d_op%0d", i, r_o), r_o, r_a, r_b, 5'($urandom_range(0, 31)),
             int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
